mode_sequencer: RTL and testbench

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/mode_sequencer_if.sv | 36 +++
 rtl/mode_sequencer.sv | 145 ++++++++++++++
 tb/tb_mode_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mode_sequencer_if.sv
// rtl/mode_sequencer_if.sv - button, loader-status and memory-ownership control bundle
//
// Signals:
//   work_btn  : raw asynchronous request to enter WORK mode
//   uart_btn  : raw asynchronous request to enter UART mode
//   uart_done : level from the UART loader, download complete
//   mode      : 1 = WORK (CPU owns memories), 0 = UART (loader owns memories)
//   cpu_en    : CPU clock-enable
//   cpu_rst   : CPU reset
//   uart_rst  : UART loader reset
//   loaded    : high while in LOADED
//   state_o   : encoded sequencer state for MMIO status
// Modports:
//   master : the sequencer (drives the control outputs)
//   slave  : the system side (drives buttons and uart_done)
interface mode_sequencer_if;
    logic       work_btn;
    logic       uart_btn;
    logic       uart_done;
    logic       mode;
    logic       cpu_en;
    logic       cpu_rst;
    logic       uart_rst;
    logic       loaded;
    logic [2:0] state_o;

    modport master (
        input  work_btn, uart_btn, uart_done,
        output mode, cpu_en, cpu_rst, uart_rst, loaded, state_o
    );

    modport slave (
        output work_btn, uart_btn, uart_done,
        input  mode, cpu_en, cpu_rst, uart_rst, loaded, state_o
    );
endinterface

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - WORK/UART memory-ownership sequencer with debounced buttons
//
// Ports:
//   clk : single clock for all logic
//   rst : synchronous active-high reset
//   bus : mode_sequencer_if.master (buttons, uart_done in; mode, cpu_en,
//         cpu_rst, uart_rst, loaded, state_o out, all registered)
module mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CPU_EN_DELAY    = 256,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               rst,
    mode_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_UART   = 3'd3,
        S_LOADED = 3'd4,
        S_SWITCH = 3'd5
    } state_t;

    // START and DRAIN are never active together, so one counter serves both.
    localparam int CNT_MAX = (CPU_EN_DELAY > DRAIN_CYCLES) ? CPU_EN_DELAY : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    // Index 0 = work button, index 1 = uart button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    state_t          state;
    state_t          state_d;
    logic [CNT_W-1:0] cnt;

    assign btn_raw = {bus.uart_btn, bus.work_btn};

    // The pulse coincides with the edge on which the stability counter
    // reaches DEBOUNCE_CYCLES; saturation keeps it from firing again until
    // the level drops and the counter clears.
    always_comb begin
        press = 2'b00;
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2[i] && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (!sync2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_W'(DEBOUNCE_CYCLES)) begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Next-state decision; a work press always outranks a uart press.
    always_comb begin
        state_d = S_SWITCH;
        case (state)
            S_START:  state_d = (cnt == CNT_W'(CPU_EN_DELAY - 1)) ? S_RUN : S_START;
            S_RUN:    state_d = press[1] ? S_DRAIN : S_RUN;
            S_DRAIN: begin
                if (press[0])
                    state_d = S_START;
                else if (cnt == CNT_W'(DRAIN_CYCLES - 1))
                    state_d = S_UART;
                else
                    state_d = S_DRAIN;
            end
            S_UART: begin
                if (press[0])
                    state_d = S_SWITCH;
                else if (bus.uart_done)
                    state_d = S_LOADED;
                else
                    state_d = S_UART;
            end
            S_LOADED: begin
                if (press[0])
                    state_d = S_SWITCH;
                else if (press[1])
                    state_d = S_UART;
                else
                    state_d = S_LOADED;
            end
            S_SWITCH: state_d = S_START;
            default:  state_d = S_SWITCH;
        endcase
    end

    // Outputs are registered from the next state so they always match the
    // state register one cycle later, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_START;
            cnt         <= '0;
            bus.mode     <= 1'b1;
            bus.cpu_en   <= 1'b0;
            bus.cpu_rst  <= 1'b1;
            bus.uart_rst <= 1'b1;
            bus.loaded   <= 1'b0;
            bus.state_o  <= S_START;
        end else begin
            state       <= state_d;
            bus.state_o <= state_d;
            // Counting only while dwelling in START or DRAIN means every
            // entry into either state begins from zero.
            if ((state_d == state) && ((state == S_START) || (state == S_DRAIN)))
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;

            case (state_d)
                S_START:  {bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded} <= 5'b10010;
                S_RUN:    {bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded} <= 5'b11010;
                S_DRAIN:  {bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded} <= 5'b10010;
                // Returning from LOADED restarts the loader with a one-cycle reset.
                S_UART:   {bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded} <=
                              {4'b0010, 1'b0} | {3'b000, (state == S_LOADED), 1'b0};
                S_LOADED: {bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded} <= 5'b00101;
                default:  {bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded} <= 5'b10110;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - table-driven scoreboard bench for mode_sequencer
module tb_mode_sequencer;

    logic clk = 1'b0;
    logic rst;

    mode_sequencer_if bus ();

    mode_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CPU_EN_DELAY   (8),
        .DRAIN_CYCLES   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Expected bundle: {state_o[2:0], mode, cpu_en, cpu_rst, uart_rst, loaded}
    typedef struct {
        logic       rst;
        logic       work;
        logic       uart;
        logic       done;
        int         cycles;
        logic [7:0] exp;
        string      name;
    } vec_t;

    localparam logic [4:0] O_RST     = 5'b10110;
    localparam logic [4:0] O_START   = 5'b10010;
    localparam logic [4:0] O_RUN     = 5'b11010;
    localparam logic [4:0] O_DRAIN   = 5'b10010;
    localparam logic [4:0] O_UART    = 5'b00100;
    localparam logic [4:0] O_UART_RS = 5'b00110;
    localparam logic [4:0] O_LOADED  = 5'b00101;
    localparam logic [4:0] O_SWITCH  = 5'b10110;

    localparam logic [2:0] ST_START  = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_UART   = 3'd3;
    localparam logic [2:0] ST_LOADED = 3'd4;
    localparam logic [2:0] ST_SWITCH = 3'd5;

    vec_t       vecs [$];
    logic [7:0] sb [$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic       prev_mode;
    logic       prev_en;

    function automatic void add(input logic r, input logic w, input logic u, input logic d,
                                input int n, input logic [2:0] st, input logic [4:0] o,
                                input string nm);
        vec_t v;
        v.rst = r; v.work = w; v.uart = u; v.done = d;
        v.cycles = n; v.exp = {st, o}; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Reach UART from RUN with a clean uart press released after the pulse.
    function automatic void to_uart(input string tag);
        add(0, 0, 1, 0, 5, ST_RUN,   O_RUN,   {tag, "_pre"});
        add(0, 0, 1, 0, 1, ST_DRAIN, O_DRAIN, {tag, "_drain"});
        add(0, 0, 0, 0, 1, ST_DRAIN, O_DRAIN, {tag, "_drain2"});
        add(0, 0, 0, 0, 1, ST_UART,  O_UART,  {tag, "_uart"});
    endfunction

    // From START entry: 7 more cycles in START, RUN on the 8th.
    function automatic void start_to_run(input string tag);
        add(0, 0, 0, 0, 7, ST_START, O_START, {tag, "_start"});
        add(0, 0, 0, 0, 1, ST_RUN,   O_RUN,   {tag, "_run"});
    endfunction

    // Invariants: uart_rst high whenever mode=1; mode never flips around cpu_en=1.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.mode && !bus.uart_rst) begin
                failures++;
                $display("FAIL inv_uart_rst: mode=%0b uart_rst=%0b required uart_rst=1", bus.mode, bus.uart_rst);
            end
            if (bus.mode !== prev_mode) begin
                checks++;
                if (bus.cpu_en || prev_en) begin
                    failures++;
                    $display("FAIL inv_mode_cpu_en: mode %0b->%0b with cpu_en %0b->%0b required cpu_en=0",
                             prev_mode, bus.mode, prev_en, bus.cpu_en);
                end
            end
            prev_mode = bus.mode;
            prev_en   = bus.cpu_en;
        end
    end

    initial begin
        logic [7:0] got;
        logic [7:0] want;

        rst = 1'b1;
        bus.work_btn  = 1'b0;
        bus.uart_btn  = 1'b0;
        bus.uart_done = 1'b0;

        // Reset and power-up START sequence
        add(1, 0, 0, 0, 2, ST_START, O_RST,   "reset_hold");
        add(0, 0, 0, 0, 1, ST_START, O_START, "reset_release");
        add(0, 0, 0, 0, 6, ST_START, O_START, "start_wait");
        add(0, 0, 0, 0, 1, ST_RUN,   O_RUN,   "cpu_en_at_8");
        // Short glitch in RUN is rejected
        add(0, 0, 1, 0, 3, ST_RUN,   O_RUN,   "glitch_high");
        add(0, 0, 0, 0, 6, ST_RUN,   O_RUN,   "glitch_gone");
        // Long uart press: DRAIN 6 cycles after rise, UART 2 later, no repeat
        add(0, 0, 1, 0, 5, ST_RUN,   O_RUN,   "uart_press_pre");
        add(0, 0, 1, 0, 1, ST_DRAIN, O_DRAIN, "drain_entry");
        add(0, 0, 1, 0, 1, ST_DRAIN, O_DRAIN, "drain_hold");
        add(0, 0, 1, 0, 1, ST_UART,  O_UART,  "uart_entry");
        add(0, 0, 1, 0, 2, ST_UART,  O_UART,  "uart_btn_held");
        add(0, 0, 0, 0, 8, ST_UART,  O_UART,  "uart_idle");
        // Download complete, then work press through SWITCH
        add(0, 0, 0, 1, 1, ST_LOADED, O_LOADED, "loaded_entry");
        add(0, 0, 0, 0, 2, ST_LOADED, O_LOADED, "loaded_hold");
        add(0, 1, 0, 0, 5, ST_LOADED, O_LOADED, "work_press_pre");
        add(0, 1, 0, 0, 1, ST_SWITCH, O_SWITCH, "switch_entry");
        add(0, 1, 0, 0, 1, ST_START,  O_START,  "switch_one_cycle");
        start_to_run("after_switch");
        // Simultaneous presses in UART: work wins
        to_uart("u2");
        add(0, 1, 1, 0, 5, ST_UART,   O_UART,   "both_pre");
        add(0, 1, 1, 0, 1, ST_SWITCH, O_SWITCH, "both_switch");
        add(0, 1, 1, 0, 1, ST_START,  O_START,  "both_start");
        start_to_run("after_both");
        // Work press landing during DRAIN aborts to START
        add(0, 0, 1, 0, 1, ST_RUN,   O_RUN,   "abort_uart_rise");
        add(0, 1, 1, 0, 4, ST_RUN,   O_RUN,   "abort_pre");
        add(0, 1, 1, 0, 1, ST_DRAIN, O_DRAIN, "abort_drain");
        add(0, 1, 1, 0, 1, ST_START, O_START, "abort_start");
        start_to_run("after_abort");
        // LOADED -> UART restarts the loader with a one-cycle uart_rst
        to_uart("u3");
        add(0, 0, 0, 1, 1, ST_LOADED, O_LOADED,  "reload_loaded");
        add(0, 0, 0, 0, 1, ST_LOADED, O_LOADED,  "reload_hold");
        add(0, 0, 1, 0, 5, ST_LOADED, O_LOADED,  "reload_pre");
        add(0, 0, 1, 0, 1, ST_UART,   O_UART_RS, "reload_uart_rst_pulse");
        add(0, 0, 1, 0, 1, ST_UART,   O_UART,    "reload_uart_rst_drop");
        add(0, 0, 0, 0, 3, ST_UART,   O_UART,    "reload_idle");
        // Reset mid-UART overrides everything
        add(1, 0, 0, 1, 1, ST_START, O_RST,   "reset_in_uart");
        add(0, 0, 0, 0, 1, ST_START, O_START, "reset2_release");
        add(0, 0, 0, 0, 6, ST_START, O_START, "reset2_wait");
        add(0, 0, 0, 0, 1, ST_RUN,   O_RUN,   "reset2_run");

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            bus.work_btn  = vecs[i].work;
            bus.uart_btn  = vecs[i].uart;
            bus.uart_done = vecs[i].done;
            sb.push_back(vecs[i].exp);
            repeat (vecs[i].cycles) @(posedge clk);
            #1;
            got  = {bus.state_o, bus.mode, bus.cpu_en, bus.cpu_rst, bus.uart_rst, bus.loaded};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got state=%0d mode/en/crst/urst/ld=%05b required state=%0d mode/en/crst/urst/ld=%05b",
                         vecs[i].name, got[7:5], got[4:0], want[7:5], want[4:0]);
            end
            if (i == 0) begin
                prev_mode = bus.mode;
                prev_en   = bus.cpu_en;
                mon_en    = 1'b1;
            end
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
